fib_bcd_converter: RTL and testbench



---
 rtl/fib_bcd_converter_pkg.sv | 13 +
 rtl/fib_bcd_converter_bcd_add3.sv | 12 +
 rtl/fib_bcd_converter.sv | 141 ++++++++++++++
 tb/tb_fib_bcd_converter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fib_bcd_converter_pkg.sv
// Shared types for the Fibonacci binary-to-BCD converter: FSM state encoding
// and the width of one BCD digit.
package fib_bcd_pkg;

  localparam int BCD_NIB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fib_bcd_converter_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more, so
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
  import fib_bcd_pkg::*;
(
  input  logic [BCD_NIB-1:0] i_dig,
  output logic [BCD_NIB-1:0] o_dig
);

  assign o_dig = (i_dig >= BCD_NIB'(5)) ? (i_dig + BCD_NIB'(3)) : i_dig;

endmodule

// File: rtl/fib_bcd_converter.sv
// Bit-serial double-dabble binary-to-BCD converter, one value per handshake, W+1 cycles to result.
// Optional wrap-around flag (input smaller than previous input) under FIB_BCD_WRAP_DETECT_EN.
module fib_bcd_converter
  import fib_bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BCD_NIB*DIGITS-1:0]  out_bcd,
  output logic                       out_wrap,
  output logic                       busy
);

  localparam int ACC_W = BCD_NIB * DIGITS;
  localparam int CNT_W = $clog2(W + 1);
  localparam longint unsigned MAX_BIN = (64'd1 << W) - 64'd1;
  localparam longint unsigned DEC_CAP = 64'd10 ** DIGITS;

  // The decimal range must cover the largest binary input.
  generate
    if (DEC_CAP <= MAX_BIN) begin : g_bad_digits
      $error("fib_bcd_converter: DIGITS too small for W");
    end
  endgenerate

  state_t               r_state;
  state_t               w_next_state;
  logic [W-1:0]         r_sr;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [ACC_W-1:0]     r_out_bcd;
  logic [ACC_W-1:0]     w_acc_adj;
  logic [ACC_W+W-1:0]   w_cat;
  logic [ACC_W-1:0]     w_acc_next;
  logic [W-1:0]         w_sr_next;
  logic                 w_accept;
  logic                 w_last;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_dig (r_acc[g*BCD_NIB +: BCD_NIB]),
        .o_dig (w_acc_adj[g*BCD_NIB +: BCD_NIB])
      );
    end
  endgenerate

  assign w_cat      = {w_acc_adj, r_sr} << 1;
  assign w_acc_next = w_cat[ACC_W+W-1:W];
  assign w_sr_next  = w_cat[W-1:0];

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)             w_next_state = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(1))   w_next_state = DONE;
      DONE:    if (out_ready)            w_next_state = IDLE;
      default:                           w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // The final shift's accumulator goes straight to the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_out_bcd <= '0;
    end else if (w_accept) begin
      r_sr  <= in_data;
      r_acc <= '0;
      r_cnt <= CNT_W'(W);
    end else if (r_state == SHIFT) begin
      r_sr  <= w_sr_next;
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) begin
        r_out_bcd <= w_acc_next;
      end
    end
  end

  assign out_bcd = r_out_bcd;

`ifdef FIB_BCD_WRAP_DETECT_EN
  logic [W-1:0] r_prev;
  logic         r_wrap_pend;
  logic         r_out_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_wrap_pend <= 1'b0;
      r_out_wrap  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_prev      <= in_data;
        r_wrap_pend <= (in_data < r_prev);
      end
      if (w_last) begin
        r_out_wrap <= r_wrap_pend;
      end
    end
  end

  assign out_wrap = r_out_wrap;
`else
  assign out_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Directed bench for fib_bcd_converter (W=8, DIGITS=3): reset, latency,
// backpressure, extremes, mid-conversion reset and wrap flag.
module tb_fib_bcd_converter;

`ifdef FIB_BCD_WRAP_DETECT_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        out_wrap;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  fib_bcd_converter #(.W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_wrap  (out_wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the accept cycle; returns cycles until out_valid and busy seen in cycle 1.
  task automatic wait_valid(output int lat, output logic busy1);
    tick();
    in_valid = 1'b0;
    busy1 = busy;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  int   lat;
  logic b1;
  int   bad;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bcd",   out_bcd,   12'h000);
    chk("rst_busy",      busy,      0);
    chk("rst_out_wrap",  out_wrap,  0);

    // Single conversion of 233
    in_valid = 1'b1; in_data = 8'd233; out_ready = 1'b1;
    wait_valid(lat, b1);
    chk("c233_busy",    b1,      1);
    chk("c233_latency", lat,     9);
    chk("c233_bcd",     out_bcd, 12'h233);
    chk("c233_inrdy",   in_ready, 0);
    tick();
    chk("c233_idle_rdy",   in_ready,  1);
    chk("c233_idle_vld",   out_valid, 0);
    chk("c233_bcd_hold",   out_bcd,   12'h233);

    // Backpressure on 144
    in_valid = 1'b1; in_data = 8'd144; out_ready = 1'b0;
    wait_valid(lat, b1);
    chk("c144_latency", lat,     9);
    chk("c144_bcd",     out_bcd, 12'h144);
    in_valid = 1'b1; in_data = 8'd55;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_bcd !== 12'h144 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("bp_stable", bad, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release_rdy",  in_ready, 1);
    chk("bp_release_busy", busy,     0);
    chk("bp_release_bcd",  out_bcd,  12'h144);

    // Extremes back to back: 0 then 255
    in_valid = 1'b1; in_data = 8'd0;
    wait_valid(lat, b1);
    chk("c0_latency", lat,     9);
    chk("c0_bcd",     out_bcd, 12'h000);
    in_valid = 1'b1; in_data = 8'd255;
    tick();
    chk("b2b_accept_rdy", in_ready, 1);
    wait_valid(lat, b1);
    chk("c255_busy",    b1,      1);
    chk("c255_latency", lat,     9);
    chk("c255_bcd",     out_bcd, 12'h255);
    tick();

    // Reset during the 4th SHIFT cycle of 89
    in_valid = 1'b1; in_data = 8'd89;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rdy", in_ready,  1);
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_bcd", out_bcd,   12'h000);
    chk("mid_rst_busy", busy,     0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("mid_no_result", bad, 0);

    // Wrap: 233 then 121
    in_valid = 1'b1; in_data = 8'd233; out_ready = 1'b1;
    wait_valid(lat, b1);
    chk("w233_bcd",  out_bcd,  12'h233);
    chk("w233_wrap", out_wrap, 0);
    tick();
    in_valid = 1'b1; in_data = 8'd121;
    wait_valid(lat, b1);
    chk("w121_latency", lat,     9);
    chk("w121_bcd",     out_bcd,  12'h121);
    chk("w121_wrap",    out_wrap, WRAP_EN);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
